// File: rtl/sensor_debounce_multi_pkg.sv
`default_nettype none
// sensor_debounce_multi_pkg -- per-channel debounce FSM encodings shared by the debouncer files.
// Rev 1.0
package sensor_debounce_multi_pkg;

  localparam int DEB_STATE_W = 2;

  typedef enum logic [DEB_STATE_W-1:0] {
    DEB_IDLE = 2'b01,
    DEB_WAIT = 2'b10
  } deb_state_t;

endpackage
`default_nettype wire

// File: rtl/sensor_debounce_chan.sv
`default_nettype none
// sensor_debounce_chan -- one sensor channel: synchroniser, asymmetric filter, edge pulses, sticky flag.
// Rev 1.0
module sensor_debounce_chan
  import sensor_debounce_multi_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             raw,
  input  logic             valid_level,
  input  logic             bypass,
  input  logic [CNT_W-1:0] t_on,
  input  logic [CNT_W-1:0] t_off,
  input  logic             clear,
  output logic             active,
  output logic             rise,
  output logic             fall,
  output logic             latch
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic                   stable_q;
  logic                   stable_d;
  logic                   commit_q;
  logic                   commit_d;
  logic                   active_lvl;
  deb_state_t             state_q;
  deb_state_t             state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic [CNT_W-1:0]       cnt_d;
  logic [CNT_W-1:0]       thresh;

  assign sync_lvl   = sync_q[SYNC_STAGES-1];
  assign active_lvl = stable_q ~^ valid_level;
  // Threshold follows the direction of the pending transition, read live every cycle.
  assign thresh     = active_lvl ? t_off : t_on;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_q   <= {SYNC_STAGES{~valid_level}};
      stable_q <= ~valid_level;
      state_q  <= DEB_IDLE;
      cnt_q    <= '0;
      commit_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw};
      stable_q <= stable_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      commit_q <= commit_d;
    end
  end

  always_comb begin
    state_d  = DEB_IDLE;
    cnt_d    = '0;
    stable_d = stable_q;
    if (bypass) begin
      stable_d = sync_lvl;
    end else begin
      case (state_q)
        DEB_IDLE: begin
          if (sync_lvl != stable_q) state_d = DEB_WAIT;
        end
        DEB_WAIT: begin
          if (sync_lvl == stable_q) begin
            state_d = DEB_IDLE;
          end else if (cnt_q >= thresh) begin
            stable_d = sync_lvl;
          end else begin
            state_d = DEB_WAIT;
            cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
          end
        end
        default: state_d = DEB_IDLE;
      endcase
    end
    commit_d = (stable_d != stable_q);
  end

  // Pulses and the flag key off the registered commit so they line up with the active change;
  // a polarity change alone moves active but never sets commit.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      active <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
      latch  <= 1'b0;
    end else begin
      active <= active_lvl;
      rise   <= commit_q & active_lvl;
      fall   <= commit_q & ~active_lvl;
      latch  <= commit_q | (latch & ~clear);
    end
  end

endmodule
`default_nettype wire

// File: rtl/sensor_debounce_multi.sv
`default_nettype none
// sensor_debounce_multi -- CH_NUM independent debounced sensor channels plus a global event summary.
// Rev 1.0
module sensor_debounce_multi #(
  parameter int CH_NUM      = 8,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [CH_NUM-1:0] sensor_input,
  input  logic [CH_NUM-1:0] sensor_valid_level,
  input  logic [CH_NUM-1:0] deb_bypass,
  input  logic [CNT_W-1:0]  cfg_deb_on_clk,
  input  logic [CNT_W-1:0]  cfg_deb_off_clk,
  input  logic [CH_NUM-1:0] event_clear,
  output logic [CH_NUM-1:0] sensor_active,
  output logic [CH_NUM-1:0] sensor_rise_pulse,
  output logic [CH_NUM-1:0] sensor_fall_pulse,
  output logic [CH_NUM-1:0] event_latch,
  output logic              event_any
);

  for (genvar ch = 0; ch < CH_NUM; ch++) begin : g_chan
    sensor_debounce_chan #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .sys_clk     (sys_clk),
      .sys_rst_n   (sys_rst_n),
      .raw         (sensor_input[ch]),
      .valid_level (sensor_valid_level[ch]),
      .bypass      (deb_bypass[ch]),
      .t_on        (cfg_deb_on_clk),
      .t_off       (cfg_deb_off_clk),
      .clear       (event_clear[ch]),
      .active      (sensor_active[ch]),
      .rise        (sensor_rise_pulse[ch]),
      .fall        (sensor_fall_pulse[ch]),
      .latch       (event_latch[ch])
    );
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) event_any <= 1'b0;
    else            event_any <= |event_latch;
  end

endmodule
`default_nettype wire

// File: tb/tb_sensor_debounce_multi.sv
`default_nettype none
// tb_sensor_debounce_multi -- directed stimulus with a cycle-stamped scoreboard of output changes.
// Rev 1.0
module tb_sensor_debounce_multi;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [7:0]  sensor_input;
  logic [7:0]  sensor_valid_level;
  logic [7:0]  deb_bypass;
  logic [15:0] cfg_deb_on_clk;
  logic [15:0] cfg_deb_off_clk;
  logic [7:0]  event_clear;
  logic [7:0]  sensor_active;
  logic [7:0]  sensor_rise_pulse;
  logic [7:0]  sensor_fall_pulse;
  logic [7:0]  event_latch;
  logic        event_any;

  typedef struct {
    int          cyc;
    logic [32:0] snap;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  logic [7:0]  ea = '0;
  logic [7:0]  er = '0;
  logic [7:0]  ef = '0;
  logic [7:0]  el = '0;
  logic        eany = 1'b0;
  logic [32:0] prev_snap = '0;

  sensor_debounce_multi #(
    .CH_NUM      (8),
    .CNT_W       (16),
    .SYNC_STAGES (2)
  ) dut (
    .sys_clk            (sys_clk),
    .sys_rst_n          (sys_rst_n),
    .sensor_input       (sensor_input),
    .sensor_valid_level (sensor_valid_level),
    .deb_bypass         (deb_bypass),
    .cfg_deb_on_clk     (cfg_deb_on_clk),
    .cfg_deb_off_clk    (cfg_deb_off_clk),
    .event_clear        (event_clear),
    .sensor_active      (sensor_active),
    .sensor_rise_pulse  (sensor_rise_pulse),
    .sensor_fall_pulse  (sensor_fall_pulse),
    .event_latch        (event_latch),
    .event_any          (event_any)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input int at, input string nm);
    exp_t e;
    e.cyc  = at;
    e.snap = {ea, er, ef, el, eany};
    e.name = nm;
    exp_q.push_back(e);
  endtask

  // Committed change on one channel: active + pulse + latch at 'at', pulse gone and any updated next cycle.
  task automatic commit_evt(input int ch, input bit v, input int at, input string nm);
    ea[ch] = v;
    er = '0;
    ef = '0;
    if (v) er[ch] = 1'b1;
    else   ef[ch] = 1'b1;
    el[ch] = 1'b1;
    push(at, nm);
    er = '0;
    ef = '0;
    eany = |el;
    push(at + 1, {nm, "_end"});
  endtask

  always @(negedge sys_clk) begin : monitor
    logic [32:0] snap;
    if (mon_en) begin
      snap = {sensor_active, sensor_rise_pulse, sensor_fall_pulse, event_latch, event_any};
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s missing at cyc %0d: actual=%h required=%h",
                 exp_q[0].name, exp_q[0].cyc, snap, exp_q[0].snap);
        void'(exp_q.pop_front());
      end
      if (snap !== prev_snap) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          failures++;
          $display("FAIL unexpected_change cyc=%0d actual=%h required=%h", cyc, snap, prev_snap);
        end else begin
          if (snap !== exp_q[0].snap) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", exp_q[0].name, cyc, snap, exp_q[0].snap);
          end
          void'(exp_q.pop_front());
        end
      end
      prev_snap = snap;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int p;
    sensor_input       = 8'hF0;
    sensor_valid_level = 8'h0F;
    deb_bypass         = 8'h00;
    cfg_deb_on_clk     = 16'd4;
    cfg_deb_off_clk    = 16'd10;
    event_clear        = 8'h00;

    repeat (3) @(negedge sys_clk);
    checks++;
    if ({sensor_active, sensor_rise_pulse, sensor_fall_pulse, event_latch, event_any} !== 33'h0) begin
      failures++;
      $display("FAIL reset_state actual=%h required=0",
               {sensor_active, sensor_rise_pulse, sensor_fall_pulse, event_latch, event_any});
    end
    tick(1);
    sys_rst_n = 1'b1;
    mon_en    = 1'b1;
    tick(3);

    // Clean rise on ch0, T_on=4: SYNC+T+3 = 9 clocks.
    p = cyc; sensor_input[0] = 1'b1; commit_evt(0, 1'b1, p + 9, "ch0_rise"); tick(14);
    // Release with T_off=10: 15 clocks.
    p = cyc; sensor_input[0] = 1'b0; commit_evt(0, 1'b0, p + 15, "ch0_fall"); tick(20);
    // 5-cycle glitch rejected.
    sensor_input[0] = 1'b1; tick(5); sensor_input[0] = 1'b0; tick(15);
    // 6-cycle pulse accepted, then released.
    p = cyc; sensor_input[0] = 1'b1; commit_evt(0, 1'b1, p + 9, "ch0_pulse6_rise");
    tick(6); sensor_input[0] = 1'b0; commit_evt(0, 1'b0, p + 21, "ch0_pulse6_fall");
    tick(20);

    // Polarity flip on ch1 moves active only.
    p = cyc; sensor_valid_level[1] = 1'b0; ea[1] = 1'b1; push(p + 1, "ch1_pol_low"); tick(3);
    p = cyc; sensor_valid_level[1] = 1'b1; ea[1] = 1'b0; push(p + 1, "ch1_pol_high"); tick(3);

    // Bypass on ch2: one-cycle pulse reproduced after 4 clocks.
    deb_bypass[2] = 1'b1; tick(3);
    p = cyc;
    ea[2] = 1'b1; er[2] = 1'b1; el[2] = 1'b1; push(p + 4, "ch2_byp_rise");
    eany = |el; ea[2] = 1'b0; er = '0; ef[2] = 1'b1; push(p + 5, "ch2_byp_fall");
    eany = |el; ef = '0; push(p + 6, "ch2_byp_end");
    sensor_input[2] = 1'b1; tick(1); sensor_input[2] = 1'b0; tick(8);
    deb_bypass[2] = 1'b0; tick(3);

    // Clear every latch.
    p = cyc;
    el = '0; push(p + 1, "clear_all_latch");
    eany = 1'b0; push(p + 2, "clear_all_any");
    event_clear = 8'hFF; tick(1); event_clear = 8'h00; tick(4);

    // ch3 commit with coincident clear: set wins; clear on the next cycle drops it.
    p = cyc;
    ea[3] = 1'b1; er[3] = 1'b1; el[3] = 1'b1; push(p + 9, "ch3_set_wins");
    er = '0; el[3] = 1'b0; eany = 1'b1; push(p + 10, "ch3_cleared");
    eany = 1'b0; push(p + 11, "ch3_any_clear");
    sensor_input[3] = 1'b1; tick(8); event_clear[3] = 1'b1; tick(2); event_clear[3] = 1'b0; tick(4);

    // T_on=0: 1-cycle glitch rejected, 2-cycle pulse accepted after 5 clocks.
    cfg_deb_on_clk = 16'd0; tick(2);
    sensor_input[0] = 1'b1; tick(1); sensor_input[0] = 1'b0; tick(8);
    p = cyc; sensor_input[0] = 1'b1; commit_evt(0, 1'b1, p + 5, "ch0_t0_rise");
    tick(2); sensor_input[0] = 1'b0; commit_evt(0, 1'b0, p + 17, "ch0_t0_fall");
    tick(22);

    // Simultaneous commits on active-low ch4 and ch5.
    p = cyc;
    ea[5:4] = 2'b11; er = '0; er[5:4] = 2'b11; el[5:4] = 2'b11; push(p + 5, "ch45_rise");
    er = '0; eany = |el; push(p + 6, "ch45_end");
    sensor_input[5:4] = 2'b00; tick(10);

    tick(5);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_events actual=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
